// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: EX-stage bundle between the pipeline and the HI/LO multiply/divide unit.
// Signal names match the original flat port list of muldiv_unit.
interface muldiv_unit_if;
    logic [5:0]  opcodeE;
    logic [5:0]  functE;
    logic [31:0] srcAE;
    logic [31:0] srcBE;
    logic        busyE;
    logic [31:0] mfResultE;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output opcodeE, functE, srcAE, srcBE,
        input  busyE, mfResultE, hi, lo
    );

    modport slave (
        input  opcodeE, functE, srcAE, srcBE,
        output busyE, mfResultE, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and MFHI/MFLO/MTHI/MTLO.
// Define MULDIV_DIV_EN to build the DIV state and restoring divider; otherwise DIV/DIVU are no-ops.
module muldiv_unit (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
`ifdef MULDIV_DIV_EN
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
`endif
    localparam logic [5:0] STEPS   = 6'd32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2
`ifdef MULDIV_DIV_EN
        , DIV = 2'd3
`endif
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] mcand;
    logic [63:0] prod;
    logic        neg_res;
`ifdef MULDIV_DIV_EN
    logic        neg_rem;
    logic        div_zero;
    logic        is_div;
`endif

    logic        is_r;
    logic        op_mult;
    logic        op_multu;
    logic        op_mfhi;
    logic        op_mflo;
    logic        op_mthi;
    logic        op_mtlo;
    logic        decoded;
    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_res;
`ifdef MULDIV_DIV_EN
    logic        op_div;
    logic        op_divu;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [31:0] quot;
    logic [31:0] rem;
`endif

    always_comb begin
        is_r      = (bus.opcodeE == '0);
        op_mult   = is_r && (bus.functE == F_MULT);
        op_multu  = is_r && (bus.functE == F_MULTU);
        op_mfhi   = is_r && (bus.functE == F_MFHI);
        op_mflo   = is_r && (bus.functE == F_MFLO);
        op_mthi   = is_r && (bus.functE == F_MTHI);
        op_mtlo   = is_r && (bus.functE == F_MTLO);
        decoded   = op_mult | op_multu | op_mfhi | op_mflo | op_mthi | op_mtlo;
        signed_op = op_mult;
`ifdef MULDIV_DIV_EN
        op_div    = is_r && (bus.functE == F_DIV);
        op_divu   = is_r && (bus.functE == F_DIVU);
        decoded   = decoded | op_div | op_divu;
        signed_op = signed_op | op_div;
`endif
        a_neg = signed_op & bus.srcAE[31];
        b_neg = signed_op & bus.srcBE[31];
        a_mag = a_neg ? (32'd0 - bus.srcAE) : bus.srcAE;
        b_mag = b_neg ? (32'd0 - bus.srcBE) : bus.srcBE;
    end

    // Multiply: prod holds {partial product, remaining multiplier bits}, shifted right each step.
    always_comb begin
        mul_sum = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
        mul_res = neg_res ? (64'd0 - prod) : prod;
    end

`ifdef MULDIV_DIV_EN
    // Divide: prod holds {partial remainder, dividend/quotient}, shifted left each step.
    always_comb begin
        div_shift = {prod[63:32], prod[31]};
        div_ge    = (div_shift >= {1'b0, mcand});
        div_diff  = div_shift - {1'b0, mcand};
        quot      = div_zero ? '1 : (neg_res ? (32'd0 - prod[31:0]) : prod[31:0]);
        rem       = neg_rem ? (32'd0 - prod[63:32]) : prod[63:32];
    end
`endif

    assign bus.busyE     = (state != IDLE) && decoded;
    assign bus.mfResultE = op_mfhi ? hi_r : (op_mflo ? lo_r : '0);
    assign bus.hi        = hi_r;
    assign bus.lo        = lo_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            mcand    <= '0;
            prod     <= '0;
            neg_res  <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            is_div   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (op_mult | op_multu) begin
                        mcand   <= a_mag;
                        prod    <= {32'd0, b_mag};
                        neg_res <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
                        is_div  <= 1'b0;
`endif
                        state   <= MUL;
                    end
`ifdef MULDIV_DIV_EN
                    else if (op_div | op_divu) begin
                        mcand    <= b_mag;
                        prod     <= {32'd0, a_mag};
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= (bus.srcBE == '0);
                        is_div   <= 1'b1;
                        state    <= DIV;
                    end
`endif
                    else if (op_mthi) begin
                        hi_r <= bus.srcAE;
                    end else if (op_mtlo) begin
                        lo_r <= bus.srcAE;
                    end
                end
                MUL: begin
                    if (cnt == STEPS) begin
                        state <= FIX;
                    end else begin
                        prod <= {mul_sum, prod[31:1]};
                        cnt  <= cnt + 6'd1;
                    end
                end
`ifdef MULDIV_DIV_EN
                DIV: begin
                    if (cnt == STEPS) begin
                        state <= FIX;
                    end else begin
                        if (div_ge) prod <= {div_diff[31:0], prod[30:0], 1'b1};
                        else        prod <= {div_shift[31:0], prod[30:0], 1'b0};
                        cnt <= cnt + 6'd1;
                    end
                end
`endif
                FIX: begin
`ifdef MULDIV_DIV_EN
                    if (is_div) begin
                        hi_r <= rem;
                        lo_r <= quot;
                    end else
`endif
                    begin
                        hi_r <= mul_res[63:32];
                        lo_r <= mul_res[31:0];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit against an arithmetic HI/LO model.
// Honours MULDIV_DIV_EN the same way as the design.
module tb_muldiv_unit;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int K_HILO = 0;
    localparam int K_BUSY = 1;
    localparam int K_MF   = 2;

    typedef struct {
        int          kind;
        int unsigned due;
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } chk_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;
    int total = 0;
    int bad = 0;
    chk_t sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_unit_if bus();
    muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: retire every expectation whose cycle has arrived.
    always @(negedge clk) begin
        chk_t c;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            c = sb.pop_front();
            total++;
            if (c.due < cyc) begin
                bad++;
                $display("FAIL %s: check slot %0d missed at cycle %0d", c.name, c.due, cyc);
            end else if (c.kind == K_HILO) begin
                if (bus.hi !== c.e1 || bus.lo !== c.e2) begin
                    bad++;
                    $display("FAIL %s @%0d: hi/lo got %h/%h want %h/%h", c.name, cyc, bus.hi, bus.lo, c.e1, c.e2);
                end
            end else if (c.kind == K_BUSY) begin
                if (bus.busyE !== c.e1[0]) begin
                    bad++;
                    $display("FAIL %s @%0d: busyE got %b want %b", c.name, cyc, bus.busyE, c.e1[0]);
                end
            end else begin
                if (bus.mfResultE !== c.e1 || bus.busyE !== 1'b0) begin
                    bad++;
                    $display("FAIL %s @%0d: mfResultE/busyE got %h/%b want %h/0", c.name, cyc, bus.mfResultE, bus.busyE, c.e1);
                end
            end
        end
    end

    task automatic push(input int kind, input int unsigned due, input string name,
                        input logic [31:0] e1, input logic [31:0] e2);
        chk_t c;
        int idx;
        c.kind = kind; c.due = due; c.name = name; c.e1 = e1; c.e2 = e2;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].due > due) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [5:0] op, input logic [5:0] f,
                           input logic [31:0] a, input logic [31:0] b);
        bus.opcodeE = op; bus.functE = f; bus.srcAE = a; bus.srcBE = b;
    endtask

    function automatic bit dec(input logic [5:0] op, input logic [5:0] f);
        if (op != 6'd0) return 1'b0;
        case (f)
            F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU: return 1'b1;
            F_DIV, F_DIVU: return DIV_EN;
            default: return 1'b0;
        endcase
    endfunction

    // Reference {hi,lo} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int q, r;
        case (f)
            F_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            F_MULTU: return {32'd0, a} * {32'd0, b};
            F_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // mode 0: random traffic during the op; 1: MFLO stalls from accept+5; 2: reset at step 10.
    task automatic long_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input int mode);
        int unsigned acc;
        logic [63:0] res;
        logic [5:0] wop, wf;
        bit en;
        en = dec(6'd0, f);
        present(6'd0, f, a, b);
        push(K_BUSY, cyc, "accept_idle_busy", 32'd0, 32'd0);
        tick();
        acc = cyc;
        if (!en) begin
            push(K_HILO, acc, "div_off_hilo", m_hi, m_lo);
            for (int i = 0; i < 4; i++) begin
                present(6'd0, F_MFHI, 32'd0, 32'd0);
                push(K_MF, cyc, "div_off_mfhi", m_hi, 32'd0);
                tick();
            end
            push(K_HILO, cyc, "div_off_hilo_late", m_hi, m_lo);
            present(6'd0, 6'd0, 32'd0, 32'd0);
            return;
        end
        res = ref_result(f, a, b);
        if (mode == 2) begin
            for (int i = 0; i < 10; i++) begin
                present(6'd0, F_MFHI, 32'd0, 32'd0);
                push(K_BUSY, cyc, "pre_rst_busy", 32'd1, 32'd0);
                tick();
            end
            rst = 1'b1;
            m_hi = '0; m_lo = '0;
            push(K_BUSY, cyc, "rst_busy", 32'd0, 32'd0);
            push(K_HILO, cyc, "rst_hilo", 32'd0, 32'd0);
            #5;
            rst = 1'b0;
            present(6'd0, F_MTHI, 32'h12345678, 32'd0);
            tick();
            m_hi = 32'h12345678;
            push(K_HILO, cyc, "mthi_after_rst", m_hi, m_lo);
            present(6'd0, 6'd0, 32'd0, 32'd0);
            repeat (30) tick();
            push(K_HILO, cyc, "rst_discarded", m_hi, m_lo);
            return;
        end
        push(K_HILO, acc + 33, "hilo_before_fix", m_hi, m_lo);
        push(K_HILO, acc + 34, "hilo_result", res[63:32], res[31:0]);
        for (int i = 0; i < 34; i++) begin
            if (mode == 1) begin
                wop = 6'd0;
                wf = (i < 5) ? 6'h20 : F_MFLO;
            end else begin
                case ($urandom_range(0, 2))
                    0: begin wop = 6'd0; wf = 6'd0; end
                    1: begin
                        if ($urandom_range(0, 1) == 0) begin
                            wop = 6'($urandom_range(1, 63)); wf = 6'($urandom);
                        end else begin
                            wop = 6'd0; wf = 6'(32'h20 + $urandom_range(0, 7));
                        end
                    end
                    default: begin
                        wop = 6'd0;
                        wf = ($urandom_range(0, 1) == 0) ? 6'(32'h10 + $urandom_range(0, 3))
                                                        : 6'(32'h18 + $urandom_range(0, 3));
                    end
                endcase
            end
            present(wop, wf, $urandom, $urandom);
            push(K_BUSY, cyc, "window_busy", {31'd0, dec(wop, wf)}, 32'd0);
            tick();
        end
        m_hi = res[63:32];
        m_lo = res[31:0];
        if (mode == 1) begin
            present(6'd0, F_MFLO, 32'd0, 32'd0);
            push(K_MF, cyc, "mflo_after_stall", m_lo, 32'd0);
            tick();
        end
        present(6'd0, 6'd0, 32'd0, 32'd0);
    endtask

    task automatic mt_mf();
        logic [31:0] r;
        r = $urandom;
        present(6'd0, F_MTLO, r, $urandom);
        push(K_BUSY, cyc, "mtlo_busy", 32'd0, 32'd0);
        tick();
        m_lo = r;
        push(K_HILO, cyc, "mtlo", m_hi, m_lo);
        r = $urandom;
        present(6'd0, F_MTHI, r, $urandom);
        tick();
        m_hi = r;
        push(K_HILO, cyc, "mthi", m_hi, m_lo);
        present(6'd0, F_MFHI, 32'd0, 32'd0);
        push(K_MF, cyc, "mfhi", m_hi, 32'd0);
        tick();
        present(6'd0, F_MFLO, 32'd0, 32'd0);
        push(K_MF, cyc, "mflo", m_lo, 32'd0);
        tick();
        present(6'd0, 6'h20, 32'd5, 32'd6);
        push(K_MF, cyc, "mf_unrelated_zero", 32'd0, 32'd0);
        tick();
        present(6'd0, 6'd0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [5:0] f;
        present(6'd0, F_MFHI, 32'd0, 32'd0);
        tick();
        push(K_HILO, cyc, "reset_hilo", 32'd0, 32'd0);
        push(K_MF, cyc, "reset_mf", 32'd0, 32'd0);
        tick();
        rst = 1'b0;
        present(6'd0, 6'd0, 32'd0, 32'd0);
        tick();

        long_op(F_MULT, 32'hFFFFFFFE, 32'd3, 0);
        long_op(F_MULTU, 32'hFFFFFFFE, 32'd3, 0);
        long_op(F_MULT, 32'h80000000, 32'h80000000, 0);
`ifdef MULDIV_DIV_EN
        long_op(F_DIV, 32'hFFFFFFF9, 32'd2, 0);
        long_op(F_DIVU, 32'd7, 32'd0, 0);
        long_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
        long_op(F_DIV, 32'hFFFFFF00, 32'd0, 0);
        long_op(F_DIVU, 32'hFFFFFFFF, 32'd3, 0);
`else
        long_op(F_DIV, 32'd9, 32'd3, 0);
        long_op(F_DIVU, 32'd9, 32'd3, 0);
`endif
        mt_mf();
        long_op(F_MULT, 32'd12345, 32'hFFFF0001, 1);
        for (int n = 0; n < 10; n++) begin
            f = 6'(32'h18 + $urandom_range(0, 3));
            long_op(f, pick(), pick(), 0);
            if (n % 3 == 0) mt_mf();
        end
        long_op(F_MULTU, 32'hDEADBEEF, 32'hCAFEF00D, 2);
        mt_mf();

        for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
        while (sb.size() > 0) begin
            chk_t c;
            c = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: check slot %0d never reached", c.name, c.due);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
